// File: rtl/spike_event_encoder.sv
// Spike event encoder: detects membrane-voltage threshold crossings with
// hysteresis, enforces a refractory period, emits a one-cycle spike pulse
// and queues timestamped events in a small first-word-fall-through FIFO.
module spike_event_encoder #(
  parameter int                      WIDTH         = 18,
  parameter logic signed [WIDTH-1:0] V_TH          = 18'sd2000,
  parameter logic signed [WIDTH-1:0] V_HYST        = 18'sd200,
  parameter int                      REFRAC_CYCLES = 16,
  parameter int                      TS_WIDTH      = 16,
  parameter int                      FIFO_DEPTH    = 4
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic signed [WIDTH-1:0] v_in,
  input  logic                    v_in_valid,
  output logic                    spike_pulse,
  output logic [TS_WIDTH-1:0]     ev_ts,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [15:0]             spike_count,
  output logic                    ev_overflow,
  output logic [1:0]              fsm_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Thresholds widened by one bit so TH - HYST can never wrap.
  localparam logic signed [WIDTH:0] TH_X  = $signed({V_TH[WIDTH-1], V_TH});
  localparam logic signed [WIDTH:0] HYS_X = $signed({V_HYST[WIDTH-1], V_HYST});
  localparam logic signed [WIDTH:0] LOW_X = TH_X - HYS_X;
  localparam logic [15:0] REFRAC_LOAD     = 16'(REFRAC_CYCLES - 1);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    REFRAC   = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t                state;
  logic [15:0]           refrac_cnt;
  logic [TS_WIDTH-1:0]   ts_cnt;
  logic signed [WIDTH:0] v_x;
  logic                  fire;
  logic                  re_arm;

  logic [TS_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        occ;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  assign v_x     = $signed({v_in[WIDTH-1], v_in});
  assign fire    = (state == ARMED) && v_in_valid && (v_x >= TH_X);
  assign re_arm  = v_in_valid && (v_x < LOW_X);

  assign full    = (occ == (PTR_W+1)'(FIFO_DEPTH));
  assign ev_valid = (occ != '0);
  assign do_pop  = ev_valid && ev_ready;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign do_push = fire && (!full || do_pop);

  assign ev_ts     = mem[rd_ptr];
  assign fsm_state = state;

  // Free-running timestamp, wraps silently.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  // Detection FSM with refractory counter, registered pulse and spike count.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state       <= ARMED;
      refrac_cnt  <= '0;
      spike_pulse <= 1'b0;
      spike_count <= '0;
    end else begin
      spike_pulse <= fire;
      if (fire && spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
      // Counter runs independently of v_in_valid.
      if (refrac_cnt != '0) refrac_cnt <= refrac_cnt - 16'd1;
      case (state)
        ARMED: begin
          if (fire) begin
            state      <= REFRAC;
            refrac_cnt <= REFRAC_LOAD;
          end
        end
        REFRAC: begin
          if (refrac_cnt == '0) state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (re_arm) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

  // Event FIFO storage and pointers; head is read straight from registers.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= ts_cnt;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst)                     ev_overflow <= 1'b0;
    else if (fire && full && !do_pop) ev_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: ramp, refractory/hysteresis,
// FIFO overflow, full push+pop, timestamp wrap and asynchronous reset.
module tb_spike_event_encoder;

  logic               emu_clk = 1'b0;
  logic               emu_rst = 1'b1;
  logic signed [17:0] v_in = '0;
  logic               v_in_valid = 1'b0;
  logic               ev_ready = 1'b0;
  logic               spike_pulse;
  logic [15:0]        ev_ts;
  logic               ev_valid;
  logic [15:0]        spike_count;
  logic               ev_overflow;
  logic [1:0]         fsm_state;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ts_m = '0;   // timestamp the DUT holds until the next edge

  spike_event_encoder dut (
    .emu_clk     (emu_clk),
    .emu_rst     (emu_rst),
    .v_in        (v_in),
    .v_in_valid  (v_in_valid),
    .spike_pulse (spike_pulse),
    .ev_ts       (ev_ts),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .spike_count (spike_count),
    .ev_overflow (ev_overflow),
    .fsm_state   (fsm_state)
  );

  always #5 emu_clk = ~emu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge emu_clk);
    #1;
    ts_m = ts_m + 16'd1;
  endtask

  task automatic do_reset;
    #2;
    emu_rst    = 1'b1;
    v_in       = '0;
    v_in_valid = 1'b1;
    @(posedge emu_clk);
    #1;
    emu_rst = 1'b0;
    ts_m    = '0;
  endtask

  // Drive v_in low until ARMED (bounded), then present one firing sample.
  task automatic refire(input logic rdy, output logic [15:0] t, output logic pulse);
    int   n;
    logic sv;
    n = 0;
    v_in = '0;
    v_in_valid = 1'b1;
    while (fsm_state != 2'd0 && n < 40) begin
      tick;
      n++;
    end
    chk("rearm", 32'(fsm_state), 32'd0);
    sv       = ev_ready;
    ev_ready = rdy;
    v_in     = 18'sd2500;
    t        = ts_m;
    tick;
    pulse    = spike_pulse;
    ev_ready = sv;
  endtask

  initial begin
    logic [15:0] t [6];
    logic        p;
    int          pulses;
    int          nref;

    // ---- reset state ----
    do_reset;
    chk("rst_pulse", 32'(spike_pulse), 32'd0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_ts", 32'(ev_ts), 32'd0);
    chk("rst_count", 32'(spike_count), 32'd0);
    chk("rst_ovf", 32'(ev_overflow), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);

    // ---- ramp 0..2500: fires on the v_in=2000 sample (timestamp 20) ----
    ev_ready = 1'b1;
    pulses = 0;
    nref = 0;
    for (int i = 0; i <= 25; i++) begin
      v_in = 18'(i * 100);
      tick;
      pulses += int'(spike_pulse);
      nref   += int'(fsm_state == 2'd1);
      if (i == 20) begin
        chk("ramp_pulse", 32'(spike_pulse), 32'd1);
        chk("ramp_ts", 32'(ev_ts), 32'd20);
        chk("ramp_valid", 32'(ev_valid), 32'd1);
        chk("ramp_count", 32'(spike_count), 32'd1);
        chk("ramp_state", 32'(fsm_state), 32'd1);
      end
    end

    // ---- hold high: no re-fire, 16 cycles of REFRAC then WAIT_LOW ----
    v_in = 18'sd2500;
    for (int i = 0; i < 100; i++) begin
      tick;
      pulses += int'(spike_pulse);
      nref   += int'(fsm_state == 2'd1);
    end
    chk("hold_pulses", 32'(pulses), 32'd1);
    chk("refrac_len", 32'(nref), 32'd16);
    chk("hold_state", 32'(fsm_state), 32'd2);

    v_in = 18'sd1850;
    repeat (3) tick;
    chk("hyst_1850", 32'(fsm_state), 32'd2);
    v_in = 18'sd1799;
    tick;
    chk("hyst_1799", 32'(fsm_state), 32'd0);
    v_in = 18'sd2500;
    tick;
    chk("fire2_pulse", 32'(spike_pulse), 32'd1);
    chk("fire2_count", 32'(spike_count), 32'd2);
    chk("fire2_ts", 32'(ev_ts), 32'd130);
    tick;
    chk("fire2_pop", 32'(ev_valid), 32'd0);
    chk("pulse_1cyc", 32'(spike_pulse), 32'd0);

    // ---- overflow: 5 spikes with consumer stalled ----
    do_reset;
    ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      refire(1'b0, t[k], p);
      chk("ovf_pulse", 32'(p), 32'd1);
      if (k == 3) chk("ovf_not_yet", 32'(ev_overflow), 32'd0);
    end
    chk("ovf_flag", 32'(ev_overflow), 32'd1);
    chk("ovf_count", 32'(spike_count), 32'd5);
    repeat (3) tick;
    chk("stall_valid", 32'(ev_valid), 32'd1);
    chk("stall_ts", 32'(ev_ts), 32'(t[0]));
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_pop_valid", 32'(ev_valid), 32'd1);
      chk("ovf_pop_ts", 32'(ev_ts), 32'(t[k]));
      tick;
    end
    chk("ovf_empty", 32'(ev_valid), 32'd0);
    chk("ovf_sticky", 32'(ev_overflow), 32'd1);

    // ---- full FIFO, push and pop in the same cycle ----
    do_reset;
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) refire(1'b0, t[k], p);
    refire(1'b1, t[4], p);
    chk("pp_pulse", 32'(p), 32'd1);
    chk("pp_ovf", 32'(ev_overflow), 32'd0);
    ev_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("pp_valid", 32'(ev_valid), 32'd1);
      chk("pp_ts", 32'(ev_ts), 32'(t[k]));
      tick;
    end
    chk("pp_empty", 32'(ev_valid), 32'd0);

    // ---- timestamp wrap: FFFE then earliest re-fire at 0010 ----
    do_reset;
    ev_ready = 1'b1;
    while (ts_m != 16'hFFFE) tick;
    v_in = 18'sd2500;
    tick;
    chk("wrap_ts0", 32'(ev_ts), 32'h0000FFFE);
    chk("wrap_valid0", 32'(ev_valid), 32'd1);
    refire(1'b1, t[0], p);
    chk("wrap_pulse1", 32'(p), 32'd1);
    chk("wrap_ts1", 32'(ev_ts), 32'h00000010);

    // ---- asynchronous reset in REFRAC with 3 queued events ----
    do_reset;
    ev_ready = 1'b0;
    for (int k = 0; k < 3; k++) refire(1'b0, t[k], p);
    v_in = '0;
    repeat (2) tick;
    chk("pre_state", 32'(fsm_state), 32'd1);
    chk("pre_valid", 32'(ev_valid), 32'd1);
    chk("pre_count", 32'(spike_count), 32'd3);
    #3;
    emu_rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ev_valid), 32'd0);
    chk("arst_count", 32'(spike_count), 32'd0);
    chk("arst_state", 32'(fsm_state), 32'd0);
    chk("arst_ts", 32'(ev_ts), 32'd0);
    @(posedge emu_clk);
    #1;
    emu_rst = 1'b0;
    ts_m = '0;
    tick;
    chk("post_valid", 32'(ev_valid), 32'd0);
    chk("post_ovf", 32'(ev_overflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
